hazard_control_unit: RTL

Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards, taken-branch redirects, data-memory wait states and multi-cycle MUL/DIV execution, and drives per-stage write-enable and bubble controls plus the MUL/DIV start pulse. A small state machine holds the pipeline through multi-cycle events. A saturating counter records stalled cycles for performance monitoring. Register forwarding is handled separately; this block decides only when stages advance, hold or flush.

---
 rtl/hazard_control_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Central stall/flush sequencer for the 5-stage pipeline. Decides each cycle
// whether each pipeline register advances, holds or is loaded with a NOP, and
// issues the start pulse to the multi-cycle MUL/DIV unit. A three-state FSM
// (RUN, MD_WAIT, MEM_WAIT) holds the pipeline through multi-cycle events, and
// a saturating counter records every cycle in which the PC was held.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   IF_ID_rs1, IF_ID_rs2     source registers of the instruction in ID
//   ID_EX_rd                 destination register of the instruction in EX
//   ID_EX_memread            EX instruction is a load
//   ID_EX_muldiv             EX instruction is a multi-cycle MUL/DIV
//   muldiv_done              MUL/DIV result valid this cycle (1-cycle pulse)
//   EX_branch_taken          branch/jump resolved taken in EX
//   dmem_req, dmem_ready     MEM-stage data memory access / completion
//   perf_clr                 clears stall_cycles
//   pc_write                 PC updates
//   IF_ID_write/_flush       hold / zero IF/ID
//   ID_EX_write/_bubble      hold / NOP into ID/EX
//   EX_MEM_write/_bubble     hold / NOP into EX/MEM
//   MEM_WB_bubble            NOP into MEM/WB
//   muldiv_start             one-cycle start pulse to the MUL/DIV unit
//   stall_cycles             saturating count of cycles with pc_write = 0
//   state_dbg                current FSM state (RUN=0, MD_WAIT=1, MEM_WAIT=2)
//
// Handshakes: a data-memory access is outstanding while dmem_req=1 and
// completes in the cycle dmem_ready=1 (ready acts as the completion strobe for
// the request). A MUL/DIV operation begins with a one-cycle muldiv_start and
// completes in the cycle muldiv_done=1; done in the start cycle is ignored.
// -----------------------------------------------------------------------------
module hazard_control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_rs1,
   input  logic [4:0]  IF_ID_rs2,
   input  logic [4:0]  ID_EX_rd,
   input  logic        ID_EX_memread,
   input  logic        ID_EX_muldiv,
   input  logic        muldiv_done,
   input  logic        EX_branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        perf_clr,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        IF_ID_flush,
   output logic        ID_EX_write,
   output logic        ID_EX_bubble,
   output logic        EX_MEM_write,
   output logic        EX_MEM_bubble,
   output logic        MEM_WB_bubble,
   output logic        muldiv_start,
   output logic [15:0] stall_cycles,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MD_WAIT  = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       load_use;
   logic       run_eval;

   assign state_dbg = state_q;

   assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                     ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_write  = 1'b1;
      EX_MEM_bubble = 1'b0;
      MEM_WB_bubble = 1'b0;
      muldiv_start  = 1'b0;
      state_d       = state_q;
      run_eval      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (dmem_req && !dmem_ready) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_write  = 1'b0;
               MEM_WB_bubble = 1'b1;
               state_d       = ST_MEM_WAIT;
            end else begin
               run_eval = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ready) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_write  = 1'b0;
               MEM_WB_bubble = 1'b1;
            end else begin
               // Release cycle: hazards pending behind the memory access act now.
               run_eval = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_MD_WAIT: begin
            if (!muldiv_done) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_bubble = 1'b1;
            end else begin
               // Done cycle: defaults let EX/MEM capture the result.
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Shared RUN priority chain (memory stall already handled above).
      if (run_eval) begin
         if (ID_EX_muldiv) begin
            muldiv_start  = 1'b1;
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
            state_d       = ST_MD_WAIT;
         end else if (EX_branch_taken) begin
            // Branch wins over load-use: the dependent instruction is flushed.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
         end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
         end
      end

      if (rst) begin
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_write   = 1'b0;
         ID_EX_bubble  = 1'b1;
         EX_MEM_write  = 1'b0;
         EX_MEM_bubble = 1'b1;
         MEM_WB_bubble = 1'b1;
         muldiv_start  = 1'b0;
         state_d       = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // pc_write is low during reset too, so reset must be tested first.
   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         stall_cycles <= 16'd0;
      end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule
